// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory
// responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_write;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_write, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_write, resp_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle stores, fixed-latency loads with
// one-cycle response pulses and no response backpressure.
module dmem_responder #(
    parameter int READ_LATENCY = 2,
    parameter int DEPTH        = 1024
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

    state_t      state;
    state_t      stateNext;
    logic [2:0]  cnt;
    logic [9:0]  rdAddr;
    logic [31:0] mem [DEPTH];

    logic accept;
    logic doStore;
    logic loadBypass;
    logic loadStart;
    logic rdDone;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (loadStart) stateNext = RD_WAIT;
            RD_WAIT: if (rdDone)    stateNext = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is accepted or written during reset.
    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        accept        = bus.req_valid && bus.req_ready;
        doStore       = accept && bus.req_write;
        loadBypass    = accept && !bus.req_write && (READ_LATENCY == 1);
        loadStart     = accept && !bus.req_write && (READ_LATENCY != 1);
        rdDone        = (state == RD_WAIT) && (cnt == 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (loadStart) begin
            cnt <= LAT_M1;
        end else if (state == RD_WAIT) begin
            cnt <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (loadStart) rdAddr <= bus.req_addr;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (doStore) mem[bus.req_addr] <= bus.req_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_write <= 1'b0;
            bus.resp_rdata <= 32'd0;
        end else begin
            bus.resp_valid <= doStore || loadBypass || rdDone;
            bus.resp_write <= doStore;
            if (loadBypass)  bus.resp_rdata <= mem[bus.req_addr];
            else if (rdDone) bus.resp_rdata <= mem[rdAddr];
            else             bus.resp_rdata <= 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at READ_LATENCY 2, 1 and 7 with a
// response scoreboard keyed on expected arrival cycle.
module tb_dmem_responder;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
    int          sel;
    int          lat;
    int          cyc;
    int          checks;
    int          errors;
    exp_t        q[$];

    logic        rdy;
    logic        rv;
    logic        rw;
    logic [31:0] rd;

    dmem_responder_if b2 ();
    dmem_responder_if b1 ();
    dmem_responder_if b7 ();

    assign b2.req_valid = v && (sel == 0);
    assign b1.req_valid = v && (sel == 1);
    assign b7.req_valid = v && (sel == 2);
    assign b2.req_write = w;
    assign b1.req_write = w;
    assign b7.req_write = w;
    assign b2.req_addr  = a;
    assign b1.req_addr  = a;
    assign b7.req_addr  = a;
    assign b2.req_wdata = d;
    assign b1.req_wdata = d;
    assign b7.req_wdata = d;

    dmem_responder #(.READ_LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    dmem_responder #(.READ_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_responder #(.READ_LATENCY(7)) u7 (.clk(clk), .rst(rst), .bus(b7));

    always_comb begin
        rdy = b2.req_ready;
        rv  = b2.resp_valid;
        rw  = b2.resp_write;
        rd  = b2.resp_rdata;
        if (sel == 1) begin
            rdy = b1.req_ready;
            rv  = b1.resp_valid;
            rw  = b1.resp_write;
            rd  = b1.resp_rdata;
        end else if (sel == 2) begin
            rdy = b7.req_ready;
            rv  = b7.resp_valid;
            rw  = b7.resp_write;
            rd  = b7.resp_rdata;
        end
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rv) begin
            if (q.size() == 0) begin
                chk("spurious_resp_valid", {31'b0, rv}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_write", {31'b0, rw}, {31'b0, e.wr});
                chk("resp_rdata", rd, e.data);
            end
        end else begin
            chk("idle_rdata", rd, 32'd0);
            chk("idle_write", {31'b0, rw}, 32'd0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("resp_valid_missing", {31'b0, rv}, 32'd1);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic req(input logic wr, input logic [9:0] ad,
                       input logic [31:0] dat);
        exp_t e;
        chk("req_ready", {31'b0, rdy}, 32'd1);
        v = 1'b1;
        w = wr;
        a = ad;
        d = dat;
        e.cyc  = cyc + (wr ? 1 : lat);
        e.wr   = wr;
        e.data = wr ? 32'd0 : dat;
        q.push_back(e);
        tick();
        v = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        v      = 1'b0;
        w      = 1'b0;
        a      = '0;
        d      = '0;
        sel    = 0;
        lat    = 2;

        tick();
        tick();
        chk("reset_ready", {31'b0, rdy}, 32'd0);
        chk("reset_valid", {31'b0, rv}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, rdy}, 32'd1);

        req(1'b1, 10'h011, 32'h0101_0101);
        req(1'b0, 10'h011, 32'h0101_0101);
        chk("ready_rdwait", {31'b0, rdy}, 32'd0);
        tick();
        chk("ready_at_resp", {31'b0, rdy}, 32'd1);
        req(1'b1, 10'h012, 32'h1212_1212);
        req(1'b0, 10'h012, 32'h1212_1212);
        tick();

        req(1'b1, 10'h3FF, 32'hDEAD_BEEF);
        req(1'b0, 10'h3FF, 32'hDEAD_BEEF);
        tick();

        chk("ready_pre_abort", {31'b0, rdy}, 32'd1);
        v = 1'b1;
        w = 1'b0;
        a = 10'h011;
        tick();
        chk("ready_abort_wait", {31'b0, rdy}, 32'd0);
        rst = 1'b1;
        w   = 1'b1;
        d   = 32'hBADB_AD00;
        #1;
        chk("ready_in_reset", {31'b0, rdy}, 32'd0);
        tick();
        chk("ready_in_reset2", {31'b0, rdy}, 32'd0);
        tick();
        v   = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_post_reset", {31'b0, rdy}, 32'd1);
        repeat (6) tick();
        req(1'b0, 10'h011, 32'h0101_0101);
        tick();

        sel = 1;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            req(1'b1, 10'h005, 32'hA500_0000 + 32'(i * 3 + 1));
            req(1'b0, 10'h005, 32'hA500_0000 + 32'(i * 3 + 1));
        end
        tick();

        sel = 2;
        lat = 7;
        req(1'b1, 10'h020, 32'h7777_0007);
        req(1'b0, 10'h020, 32'h7777_0007);
        for (int i = 0; i < 6; i++) begin
            chk("ready_wait7", {31'b0, rdy}, 32'd0);
            tick();
        end
        chk("ready_after7", {31'b0, rdy}, 32'd1);
        req(1'b1, 10'h021, 32'h0000_0021);

        repeat (4) tick();
        chk("scoreboard_drain", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
